// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: decoder state encoding and
// unipolar-to-bipolar conversion used by the decoder and its models.
package sc_pkg;

    typedef enum logic {
        S2B_IDLE  = 1'b0,
        S2B_ACCUM = 1'b1
    } sc_s2b_state_t;

    // Bipolar value of a ones count over a window of 2^width samples.
    function automatic logic signed [31:0] sc_bipolar(input logic [31:0] count,
                                                      input int unsigned width);
        return $signed((count << 1) - (32'd1 << width));
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Window sample counter plus ones accumulator over 2^WIDTH enabled samples;
// self-clears after the last sample of each window.
module sc_ones_counter #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           en,
    input  logic           x,
    output logic [WIDTH:0] acc,
    output logic           last
);

    logic [WIDTH-1:0] cnt;

    assign last = en && (cnt == {WIDTH{1'b1}});

    // acc is one bit wider than cnt, so a full window of ones still fits.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (en) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc + {{WIDTH{1'b0}}, x};
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_s2b.sv
// Stochastic-to-binary decoder: counts ones over a 2^WIDTH-sample window and
// reports the unipolar count and the signed bipolar value with a valid pulse.
module sc_s2b
    import sc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  en,
    input  logic                  x,
    output logic                  busy,
    output logic                  valid,
    output logic [WIDTH:0]        count,
    output logic signed [WIDTH+1:0] bvalue
);

    sc_s2b_state_t state_q, state_d;

    logic                    cnt_clr;
    logic                    cnt_en;
    logic                    last;
    logic [WIDTH:0]          acc;
    logic [WIDTH:0]          sum_p0;
    logic signed [WIDTH+1:0] bip_p0;

    assign cnt_en  = en && (state_q == S2B_ACCUM);
    assign cnt_clr = (state_q == S2B_IDLE) && start;

    sc_ones_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .x    (x),
        .acc  (acc),
        .last (last)
    );

    // The last sample is folded in here rather than waiting for acc to absorb it.
    assign sum_p0 = acc + {{WIDTH{1'b0}}, x};
    assign bip_p0 = (WIDTH+2)'(sc_bipolar(32'(sum_p0), WIDTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S2B_IDLE: begin
                if (start) state_d = S2B_ACCUM;
            end
            S2B_ACCUM: begin
                if (last && !CONTINUOUS) state_d = S2B_IDLE;
            end
            default: state_d = S2B_IDLE;
        endcase
    end

    // ---- output stage: result registers and one-cycle valid ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S2B_IDLE;
            busy    <= 1'b0;
            valid   <= 1'b0;
            count   <= '0;
            bvalue  <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == S2B_ACCUM);
            valid   <= last;
            if (last) begin
                count  <= sum_p0;
                bvalue <= bip_p0;
            end
        end
    end

endmodule

// File: tb/tb_sc_s2b.sv
// Bench for sc_s2b: one-shot and continuous instances driven by shared
// samples, checked every cycle against a window-queue model plus literal pins.
module tb_sc_s2b;
    import sc_pkg::*;

    localparam int W = 4;
    localparam int N = 16;

    logic clk = 1'b0;
    logic reset, start0, start1, en, x;
    logic busy0, valid0, busy1, valid1;
    logic [W:0] count0, count1;
    logic signed [W+1:0] bv0, bv1;

    always #5 clk = ~clk;

    sc_s2b #(.WIDTH(W), .CONTINUOUS(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .en(en), .x(x),
        .busy(busy0), .valid(valid0), .count(count0), .bvalue(bv0));

    sc_s2b #(.WIDTH(W), .CONTINUOUS(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .en(en), .x(x),
        .busy(busy1), .valid(valid1), .count(count1), .bvalue(bv1));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit armed = 1'b0;

    // Model state: whether a window is open and the bits accepted so far.
    bit m_active[2];
    bit win[2][$];
    int e_busy[2], e_valid[2], e_count[2], e_bv[2];

    // Valid events seen on the DUTs: cycle stamp, count, bipolar value.
    int ev_cyc[2][$];
    int ev_cnt[2][$];
    int ev_bv[2][$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int m = 0; m < 2; m++) begin
            bit st;
            st = (m == 0) ? start0 : start1;
            e_valid[m] = 0;
            if (reset) begin
                m_active[m] = 0;
                win[m].delete();
                e_count[m] = 0;
                e_bv[m] = 0;
                armed = 1'b1;
            end else if (!m_active[m]) begin
                if (st) begin
                    m_active[m] = 1;
                    win[m].delete();
                end
            end else if (en) begin
                win[m].push_back(x);
                if (win[m].size() == N) begin
                    int ones;
                    ones = 0;
                    foreach (win[m][i]) ones += int'(win[m][i]);
                    e_count[m] = ones;
                    e_bv[m] = 2 * ones - N;
                    e_valid[m] = 1;
                    win[m].delete();
                    m_active[m] = (m == 1);
                end
            end
            e_busy[m] = m_active[m] ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy0", int'(busy0), e_busy[0]);
            chk("valid0", int'(valid0), e_valid[0]);
            chk("count0", int'(count0), e_count[0]);
            chk("bvalue0", int'(bv0), e_bv[0]);
            chk("busy1", int'(busy1), e_busy[1]);
            chk("valid1", int'(valid1), e_valid[1]);
            chk("count1", int'(count1), e_count[1]);
            chk("bvalue1", int'(bv1), e_bv[1]);
            if (valid0 === 1'b1) begin
                ev_cyc[0].push_back(cyc); ev_cnt[0].push_back(int'(count0)); ev_bv[0].push_back(int'(bv0));
            end
            if (valid1 === 1'b1) begin
                ev_cyc[1].push_back(cyc); ev_cnt[1].push_back(int'(count1)); ev_bv[1].push_back(int'(bv1));
            end
        end
    end

    task automatic tick(input bit r, input bit s0, input bit s1, input bit e, input bit xv);
        @(negedge clk);
        reset = r; start0 = s0; start1 = s1; en = e; x = xv;
    endtask

    task automatic clear_events();
        for (int m = 0; m < 2; m++) begin
            ev_cyc[m].delete(); ev_cnt[m].delete(); ev_bv[m].delete();
        end
    endtask

    task automatic pop_ev(input string name, input int m, input int base,
                          input int dcyc, input int cnt, input int bv);
        if (ev_cyc[m].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no valid pulse, expected count %0d", name, cnt);
        end else begin
            chk({name, "_latency"}, ev_cyc[m].pop_front() - base, dcyc);
            chk({name, "_count"}, ev_cnt[m].pop_front(), cnt);
            chk({name, "_bvalue"}, ev_bv[m].pop_front(), bv);
        end
    endtask

    initial begin
        int s;
        reset = 1'b1; start0 = 0; start1 = 0; en = 0; x = 0;
        repeat (2) tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_valid", int'(valid0), 0);
        chk("rst_count", int'(count0), 0);
        chk("rst_bvalue", int'(bv0), 0);
        chk("pkg_bipolar_max", int'(sc_bipolar(32'd16, 4)), 16);
        chk("pkg_bipolar_neg", int'(sc_bipolar(32'd4, 4)), -8);
        clear_events();

        // All ones
        tick(0, 1, 0, 1, 1); s = cyc;
        repeat (N) tick(0, 0, 0, 1, 1);
        repeat (3) tick(0, 0, 0, 0, 0);
        pop_ev("ones", 0, s, 17, 16, 16);
        chk("ones_extra", ev_cyc[0].size(), 0);

        // All zeros
        tick(0, 1, 0, 0, 0); s = cyc;
        repeat (N) tick(0, 0, 0, 1, 0);
        repeat (3) tick(0, 0, 0, 0, 0);
        pop_ev("zeros", 0, s, 17, 0, -16);

        // Alternating 1,0
        tick(0, 1, 0, 0, 0); s = cyc;
        for (int i = 0; i < N; i++) tick(0, 0, 0, 1, (i % 2) == 0);
        repeat (3) tick(0, 0, 0, 0, 0);
        pop_ev("alt", 0, s, 17, 8, 0);

        // en toggles; x is 1 only when en=0 and must be ignored
        tick(0, 1, 0, 0, 0); s = cyc;
        for (int i = 0; i < 2 * N; i++) tick(0, 0, 0, (i % 2) == 0, (i % 2) != 0);
        repeat (3) tick(0, 0, 0, 0, 0);
        pop_ev("en_gap", 0, s, 32, 0, -16);

        // Reset on the 7th sample aborts the window
        tick(0, 1, 0, 0, 0);
        repeat (6) tick(0, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 1);
        tick(0, 0, 0, 0, 0);
        chk("abort_busy", int'(busy0), 0);
        chk("abort_count", int'(count0), 0);
        chk("abort_bvalue", int'(bv0), 0);
        repeat (20) tick(0, 0, 0, 1, 1);
        chk("abort_no_valid", ev_cyc[0].size(), 0);

        // Start pulse mid-window is ignored
        tick(0, 1, 0, 0, 0); s = cyc;
        repeat (5) tick(0, 0, 0, 1, 1);
        tick(0, 1, 0, 1, 1);
        repeat (10) tick(0, 0, 0, 1, 1);
        repeat (3) tick(0, 0, 0, 0, 0);
        pop_ev("mid_start", 0, s, 17, 16, 16);
        chk("mid_start_extra", ev_cyc[0].size(), 0);

        // Continuous instance: back-to-back windows from one start
        clear_events();
        tick(0, 0, 1, 0, 0); s = cyc;
        repeat (N) tick(0, 0, 0, 1, 1);
        repeat (4) tick(0, 0, 0, 1, 1);
        repeat (12) tick(0, 0, 0, 1, 0);
        repeat (3) tick(0, 0, 0, 0, 0);
        pop_ev("cont_w0", 1, s, 17, 16, 16);
        pop_ev("cont_w1", 1, s, 33, 4, -8);
        chk("cont_busy_held", int'(busy1), 1);

        // One-shot instance: start coincident with valid
        clear_events();
        tick(0, 1, 0, 0, 0); s = cyc;
        repeat (N) tick(0, 0, 0, 1, 1);
        tick(0, 1, 0, 0, 0);
        chk("coinc_valid", int'(valid0), 1);
        repeat (N) tick(0, 0, 0, 1, 0);
        repeat (3) tick(0, 0, 0, 0, 0);
        pop_ev("coinc_first", 0, s, 17, 16, 16);
        pop_ev("coinc_second", 0, s, 34, 0, -16);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++)
            tick(($urandom % 300) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0,
                 ($urandom % 4) != 0, $urandom % 2);
        repeat (3) tick(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
